// File: rtl/fan_mode_sequencer.sv
// Fan control sequencer: power, speed, operating mode and auto-off countdown.
// Every output is registered; keys and ticks sampled on one edge take effect on that same edge.
module fan_mode_sequencer #(
    parameter int TIMER_STEP_S = 1800,
    parameter int TIMER_MAX_S  = 3600,
    parameter int NAT_STEP_S   = 5,
    parameter int SLEEP_STEP_S = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1s,
    input  logic        tick_500ms,
    input  logic        key_power,
    input  logic        key_speed,
    input  logic        key_mode,
    input  logic        key_timer,
    output logic        fan_on,
    output logic [1:0]  speed,
    output logic [1:0]  mode,
    output logic [11:0] remain_s,
    output logic        timer_led
);

    localparam int STEP_MAX = (NAT_STEP_S > SLEEP_STEP_S) ? NAT_STEP_S : SLEEP_STEP_S;
    localparam int SW       = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

    typedef enum logic [1:0] {S_OFF, S_NORMAL, S_NATURAL, S_SLEEP} state_t;

    state_t         state_q, state_d;
    logic [1:0]     speed_d, mode_d;
    logic [SW-1:0]  step_q, step_d;
    logic           dir_down_q, dir_down_d;
    logic [11:0]    remain_d;
    logic           led_d, fan_on_d;
    logic           run, expire, go_off;
    logic [12:0]    timer_sum;

    assign run       = (state_q != S_OFF);
    assign timer_sum = {1'b0, remain_s} + 13'(TIMER_STEP_S);
    // A key_timer press in the same cycle suppresses the decrement, so it also suppresses expiry.
    assign expire    = run && !key_timer && tick_1s && (remain_s == 12'd1);
    assign go_off    = run && (key_power || expire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OFF;
            fan_on     <= 1'b0;
            speed      <= 2'd0;
            mode       <= 2'd0;
            remain_s   <= 12'd0;
            timer_led  <= 1'b0;
            step_q     <= '0;
            dir_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fan_on     <= fan_on_d;
            speed      <= speed_d;
            mode       <= mode_d;
            remain_s   <= remain_d;
            timer_led  <= led_d;
            step_q     <= step_d;
            dir_down_q <= dir_down_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_OFF) begin
            if (key_power) state_d = S_NORMAL;
        end else if (go_off) begin
            state_d = S_OFF;
        end else if (key_mode) begin
            case (state_q)
                S_NORMAL:  state_d = S_NATURAL;
                S_NATURAL: state_d = S_SLEEP;
                default:   state_d = S_NORMAL;
            endcase
        end
    end

    always_comb begin
        fan_on_d = (state_d != S_OFF);
        case (state_d)
            S_NATURAL: mode_d = 2'd1;
            S_SLEEP:   mode_d = 2'd2;
            default:   mode_d = 2'd0;
        endcase
    end

    always_comb begin
        speed_d    = speed;
        remain_d   = remain_s;
        led_d      = timer_led;
        step_d     = step_q;
        dir_down_d = dir_down_q;
        if (!run) begin
            if (key_power) begin
                speed_d    = 2'd1;
                remain_d   = 12'd0;
                led_d      = 1'b0;
                step_d     = '0;
                dir_down_d = 1'b0;
            end
        end else if (go_off) begin
            speed_d    = 2'd0;
            remain_d   = 12'd0;
            led_d      = 1'b0;
            step_d     = '0;
            dir_down_d = 1'b0;
        end else begin
            if (key_timer)
                remain_d = (timer_sum <= 13'(TIMER_MAX_S)) ? timer_sum[11:0] : 12'd0;
            else if (tick_1s && remain_s != 12'd0)
                remain_d = remain_s - 12'd1;
            // Blink phase restarts at 0 whenever the timer is newly armed or stops.
            if (remain_d == 12'd0 || remain_s == 12'd0)
                led_d = 1'b0;
            else if (tick_500ms)
                led_d = ~timer_led;

            if (key_mode) begin
                case (state_q)
                    S_NORMAL: begin
                        speed_d    = 2'd1;
                        dir_down_d = 1'b0;
                        step_d     = '0;
                    end
                    S_NATURAL: step_d = '0;
                    default: ;
                endcase
            end else if (key_speed && state_q == S_NORMAL) begin
                speed_d = (speed == 2'd3) ? 2'd1 : speed + 2'd1;
            end else if (tick_1s && state_q == S_NATURAL) begin
                if (step_q == SW'(NAT_STEP_S - 1)) begin
                    step_d = '0;
                    if (!dir_down_q) begin
                        speed_d = speed + 2'd1;
                        if (speed == 2'd2) dir_down_d = 1'b1;
                    end else begin
                        speed_d = speed - 2'd1;
                        if (speed == 2'd2) dir_down_d = 1'b0;
                    end
                end else begin
                    step_d = step_q + SW'(1);
                end
            end else if (tick_1s && state_q == S_SLEEP) begin
                if (step_q == SW'(SLEEP_STEP_S - 1)) begin
                    step_d = '0;
                    if (speed > 2'd1) speed_d = speed - 2'd1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
        end
    end

endmodule
